// File: rtl/pci_bridge_pkg.sv
// Shared types and PCI command encodings for the 68040-to-PCI bridge master side.
package pci_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REG  = 3'd1,
        ARB  = 3'd2,
        ADDR = 3'd3,
        DATA = 3'd4,
        ACK  = 3'd5,
        ERR  = 3'd6
    } state_e;

    localparam logic [3:0] CMD_IO_RD  = 4'h2;
    localparam logic [3:0] CMD_IO_WR  = 4'h3;
    localparam logic [3:0] CMD_MEM_RD = 4'h6;
    localparam logic [3:0] CMD_MEM_WR = 4'h7;
    localparam logic [3:0] CMD_CFG_RD = 4'hA;
    localparam logic [3:0] CMD_CFG_WR = 4'hB;

    // Decode results captured at transfer start.
    typedef struct packed {
        logic rd;
        logic cfg0;
        logic cfg1;
        logic io;
    } cycle_t;

    // Config outranks IO; anything else is memory.
    function automatic logic [3:0] pci_cmd(input cycle_t c);
        if (c.cfg0 || c.cfg1) return c.rd ? CMD_CFG_RD : CMD_CFG_WR;
        if (c.io)             return c.rd ? CMD_IO_RD  : CMD_IO_WR;
        return c.rd ? CMD_MEM_RD : CMD_MEM_WR;
    endfunction

endpackage

// File: rtl/pci_timeout_counter.sv
// Saturating event counter; hit flags the LIMIT-th (or later) enabled clock since clear.
module pci_timeout_counter #(
    parameter int LIMIT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] TC  = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   cnt <= '0;
        else if (clr)              cnt <= '0;
        else if (en && cnt != MAX) cnt <= cnt + 1'b1;
    end

    assign hit = en && (cnt >= TC);

endmodule

// File: rtl/pci_cycle_sequencer.sv
// Master-side PCI cycle controller: one single-data-phase PCI transaction per CPU transfer,
// with retry/abort handling and local servicing of bridge-register hits.
module pci_cycle_sequencer
    import pci_bridge_pkg::*;
#(
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int RETRY_LIMIT    = 16,
    parameter int GNT_TIMEOUT    = 64
) (
    input  logic       CLK40,
    input  logic       RESET,
    input  logic       TSn,
    input  logic       RWn,
    input  logic       BRIDGE_ENn,
    input  logic       CONFIG0_SPACE,
    input  logic       CONFIG1_SPACE,
    input  logic       IO_SPACE,
    input  logic       BRIDGE_REG_SPACE,
    input  logic       GNTn,
    input  logic       DEVSELn,
    input  logic       TRDYn,
    input  logic       STOPn,
    output logic       REQn,
    output logic       FRAMEn,
    output logic       IRDYn,
    output logic [3:0] CBE,
    output logic       AD_OE,
    output logic       CFG_TYPE1,
    output logic       REG_CS,
    output logic       TAn,
    output logic       TEAn,
    output logic       BUSY
);
    state_e state, state_nxt;
    cycle_t cyc;
    logic   turn;
    logic   devsel_hit, retry_hit, gnt_hit;
    logic   start, is_cfg, retry_ev, bus_idle;
    logic   in_xfer, in_arb;

    assign start    = (state == IDLE) && !TSn && !BRIDGE_ENn;
    assign is_cfg   = cyc.cfg0 || cyc.cfg1;
    assign retry_ev = (state == DATA) && !STOPn && TRDYn && !DEVSELn;
    assign bus_idle = FRAMEn && IRDYn;
    assign in_xfer  = (state == ADDR) || (state == DATA);
    assign in_arb   = (state == ARB) && !turn;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = BRIDGE_REG_SPACE ? REG : ARB;
            REG:  state_nxt = ACK;
            ARB: begin
                if (in_arb && !GNTn && bus_idle) state_nxt = ADDR;
                else if (gnt_hit)                state_nxt = ERR;
            end
            ADDR: state_nxt = DATA;
            DATA: begin
                // Data taken wins even when STOP# accompanies it (disconnect-with-data).
                if (!DEVSELn && !TRDYn)          state_nxt = ACK;
                else if (retry_ev)               state_nxt = retry_hit ? ERR : ARB;
                else if (!STOPn)                 state_nxt = ERR;
                // Config master abort completes so software can probe empty slots.
                else if (DEVSELn && devsel_hit)  state_nxt = is_cfg ? ACK : ERR;
            end
            ACK:     state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cyc   <= '0;
            turn  <= 1'b0;
        end else begin
            state <= state_nxt;
            // One idle clock with REQ# released before re-arbitrating after a retry.
            turn  <= (state == DATA) && (state_nxt == ARB);
            if (start) cyc <= '{rd: RWn, cfg0: CONFIG0_SPACE, cfg1: CONFIG1_SPACE, io: IO_SPACE};
        end
    end

    pci_timeout_counter #(.LIMIT(DEVSEL_TIMEOUT)) u_devsel_cnt (
        .clk(CLK40), .rst(RESET), .clr(!in_xfer), .en(in_xfer), .hit(devsel_hit)
    );

    pci_timeout_counter #(.LIMIT(RETRY_LIMIT)) u_retry_cnt (
        .clk(CLK40), .rst(RESET), .clr((state == ACK) || (state == ERR)), .en(retry_ev),
        .hit(retry_hit)
    );

    pci_timeout_counter #(.LIMIT(GNT_TIMEOUT)) u_gnt_cnt (
        .clk(CLK40), .rst(RESET), .clr(!in_arb), .en(in_arb), .hit(gnt_hit)
    );

    assign REQn      = !in_arb;
    assign FRAMEn    = (state != ADDR);
    assign IRDYn     = (state != DATA);
    assign AD_OE     = (state == ADDR) || ((state == DATA) && !cyc.rd);
    assign CBE       = (state == ADDR) ? pci_cmd(cyc) : 4'h0;
    assign CFG_TYPE1 = (state == ADDR) && cyc.cfg1;
    assign REG_CS    = (state == REG);
    assign TAn       = (state != ACK);
    assign TEAn      = (state != ERR);
    assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_pci_cycle_sequencer.sv
// Scenario bench: a reactive arbiter/target drives the PCI side while a transaction-level
// model predicts command, attempt count, outcome and abort latency.
module tb_pci_cycle_sequencer;
    import pci_bridge_pkg::*;

    localparam int DEVSEL_TIMEOUT = 5;
    localparam int RETRY_LIMIT    = 16;
    localparam int GNT_TIMEOUT    = 64;
    localparam int RSP_DATA = 0, RSP_RETRY = 1, RSP_TABT = 2, RSP_NONE = 3;
    localparam int NEVER = 255;

    logic CLK40 = 1'b0, RESET = 1'b1;
    logic TSn = 1'b1, RWn = 1'b1, BRIDGE_ENn = 1'b1;
    logic CONFIG0_SPACE = 1'b0, CONFIG1_SPACE = 1'b0, IO_SPACE = 1'b0, BRIDGE_REG_SPACE = 1'b0;
    logic GNTn = 1'b1, DEVSELn = 1'b1, TRDYn = 1'b1, STOPn = 1'b1;
    logic REQn, FRAMEn, IRDYn, AD_OE, CFG_TYPE1, REG_CS, TAn, TEAn, BUSY;
    logic [3:0] CBE;

    int n_vec = 0, n_err = 0;

    typedef struct {
        bit rd, cfg0, cfg1, io, regsp, dwd, busy_ts;
        int gnt_dly, nretry, fin, dd, td;
    } scen_t;

    pci_cycle_sequencer dut (
        .CLK40(CLK40), .RESET(RESET), .TSn(TSn), .RWn(RWn), .BRIDGE_ENn(BRIDGE_ENn),
        .CONFIG0_SPACE(CONFIG0_SPACE), .CONFIG1_SPACE(CONFIG1_SPACE), .IO_SPACE(IO_SPACE),
        .BRIDGE_REG_SPACE(BRIDGE_REG_SPACE), .GNTn(GNTn), .DEVSELn(DEVSELn), .TRDYn(TRDYn),
        .STOPn(STOPn), .REQn(REQn), .FRAMEn(FRAMEn), .IRDYn(IRDYn), .CBE(CBE), .AD_OE(AD_OE),
        .CFG_TYPE1(CFG_TYPE1), .REG_CS(REG_CS), .TAn(TAn), .TEAn(TEAn), .BUSY(BUSY)
    );

    always #10 CLK40 = ~CLK40;

    function automatic scen_t mk(bit rd, bit cfg0, bit cfg1, bit io, bit regsp,
                                 int gnt_dly, int nretry, int fin, int dd, int td);
        scen_t s;
        s.rd = rd; s.cfg0 = cfg0; s.cfg1 = cfg1; s.io = io; s.regsp = regsp;
        s.gnt_dly = gnt_dly; s.nretry = nretry; s.fin = fin; s.dd = dd; s.td = td;
        s.dwd = 1'b0; s.busy_ts = 1'b0;
        return s;
    endfunction

    // Runs one CPU transfer against the scripted arbiter/target and checks it against the model.
    task automatic run_cycle(input string tag, input scen_t s);
        bit is_cfg, exp_ta;
        int exp_addr, exp_lat, rsp;
        logic [3:0] exp_cmd;
        int cyc = 0, n_addr = 0, n_ta = 0, n_tea = 0, n_reg = 0, n_req = 0, req_run = 0;
        int first_req = -1, last_addr = -1, ack_cyc = -1, reg_cyc = -1, dcyc = 0;
        int bad_cmd = 0, bad_t1 = 0, bad_oe = 0, bad_frame = 0;
        bit prev_frame = 1'b0;

        is_cfg  = s.cfg0 | s.cfg1;
        exp_cmd = is_cfg ? (s.rd ? 4'hA : 4'hB) : s.io ? (s.rd ? 4'h2 : 4'h3) : (s.rd ? 4'h6 : 4'h7);
        exp_lat = -1;
        if (s.regsp) begin
            exp_ta = 1'b1; exp_addr = 0;
        end else if (s.gnt_dly == NEVER) begin
            exp_ta = 1'b0; exp_addr = 0; exp_lat = GNT_TIMEOUT;
        end else if (s.fin == RSP_RETRY || s.nretry >= RETRY_LIMIT) begin
            exp_ta = 1'b0; exp_addr = RETRY_LIMIT;
        end else begin
            exp_addr = s.nretry + 1;
            case (s.fin)
                RSP_DATA: exp_ta = 1'b1;
                RSP_TABT: exp_ta = 1'b0;
                default: begin exp_ta = is_cfg; exp_lat = DEVSEL_TIMEOUT; end
            endcase
        end

        @(negedge CLK40);
        TSn = 1'b0; RWn = s.rd; BRIDGE_ENn = 1'b0;
        CONFIG0_SPACE = s.cfg0; CONFIG1_SPACE = s.cfg1; IO_SPACE = s.io; BRIDGE_REG_SPACE = s.regsp;
        @(negedge CLK40);
        // Scramble decode inputs: the DUT must work from what it latched.
        {RWn, CONFIG0_SPACE, CONFIG1_SPACE, IO_SPACE, BRIDGE_REG_SPACE} = 5'($urandom);
        BRIDGE_ENn = 1'b0;
        n_vec++;
        if (BUSY !== 1'b1) begin n_err++; $display("FAIL %s busy_after_ts got %b want 1", tag, BUSY); end

        while (cyc < 3000 && (ack_cyc < 0 || cyc < ack_cyc + 3)) begin
            if (!TAn)  begin n_ta++;  if (ack_cyc < 0) ack_cyc = cyc; end
            if (!TEAn) begin n_tea++; if (ack_cyc < 0) ack_cyc = cyc; end
            if (REG_CS) begin n_reg++; reg_cyc = cyc; end
            if (!REQn) begin n_req++; if (first_req < 0) first_req = cyc; end
            if (prev_frame && (IRDYn || !FRAMEn)) bad_frame++;
            if (!FRAMEn) begin
                n_addr++; last_addr = cyc; dcyc = 0;
                if (CBE !== exp_cmd) bad_cmd++;
                if (CFG_TYPE1 !== s.cfg1) bad_t1++;
                if (AD_OE !== 1'b1) bad_oe++;
            end
            if (!IRDYn) begin
                dcyc++;
                if (AD_OE !== !s.rd) bad_oe++;
            end
            prev_frame = !FRAMEn;

            TSn = (s.busy_ts && cyc == 0) ? 1'b0 : 1'b1;
            GNTn = 1'b1;
            if (!REQn) begin
                req_run++;
                if (s.gnt_dly != NEVER && req_run > s.gnt_dly) GNTn = 1'b0;
            end else req_run = 0;
            DEVSELn = 1'b1; TRDYn = 1'b1; STOPn = 1'b1;
            if (!IRDYn && dcyc >= s.dd) begin
                rsp = (n_addr - 1 < s.nretry) ? RSP_RETRY : s.fin;
                case (rsp)
                    RSP_DATA: begin
                        DEVSELn = 1'b0;
                        if (dcyc >= s.dd + s.td) begin TRDYn = 1'b0; if (s.dwd) STOPn = 1'b0; end
                    end
                    RSP_RETRY: begin DEVSELn = 1'b0; STOPn = 1'b0; end
                    RSP_TABT:  STOPn = 1'b0;
                    default: ;
                endcase
            end
            @(negedge CLK40);
            cyc++;
        end
        TSn = 1'b1; GNTn = 1'b1; DEVSELn = 1'b1; TRDYn = 1'b1; STOPn = 1'b1;

        n_vec++;
        if (ack_cyc < 0) begin n_err++; $display("FAIL %s timeout no TA/TEA within %0d clocks", tag, cyc); end
        n_vec++;
        if (n_ta != (exp_ta ? 1 : 0)) begin n_err++; $display("FAIL %s ta_pulses got %0d want %0d", tag, n_ta, exp_ta); end
        n_vec++;
        if (n_tea != (exp_ta ? 0 : 1)) begin n_err++; $display("FAIL %s tea_pulses got %0d want %0d", tag, n_tea, !exp_ta); end
        n_vec++;
        if (n_addr != exp_addr) begin n_err++; $display("FAIL %s addr_phases got %0d want %0d", tag, n_addr, exp_addr); end
        n_vec++;
        if (bad_cmd + bad_t1 + bad_oe + bad_frame != 0) begin
            n_err++;
            $display("FAIL %s phase_errors cmd=%0d type1=%0d oe=%0d frame=%0d want all 0 (cmd %h)",
                     tag, bad_cmd, bad_t1, bad_oe, bad_frame, exp_cmd);
        end
        n_vec++;
        if (n_reg != (s.regsp ? 1 : 0)) begin n_err++; $display("FAIL %s reg_cs_pulses got %0d want %0d", tag, n_reg, s.regsp); end
        if (s.regsp) begin
            n_vec++;
            if (n_req != 0 || ack_cyc != reg_cyc + 1) begin
                n_err++; $display("FAIL %s reg_path req_clocks=%0d ack_at=%0d reg_at=%0d want 0,reg+1", tag, n_req, ack_cyc, reg_cyc);
            end
        end
        if (exp_lat > 0) begin
            n_vec++;
            if (ack_cyc - (s.gnt_dly == NEVER ? first_req : last_addr) != exp_lat) begin
                n_err++; $display("FAIL %s abort_latency got %0d want %0d", tag,
                                  ack_cyc - (s.gnt_dly == NEVER ? first_req : last_addr), exp_lat);
            end
        end
        n_vec++;
        if ({BUSY, REQn, FRAMEn, IRDYn, AD_OE, TAn, TEAn} !== 7'b0111011) begin
            n_err++; $display("FAIL %s idle_after got %b want 0111011", tag, {BUSY, REQn, FRAMEn, IRDYn, AD_OE, TAn, TEAn});
        end
    endtask

    task automatic test_reset();
        #25;
        n_vec++;
        if ({REQn, FRAMEn, IRDYn, TAn, TEAn, AD_OE, CBE, CFG_TYPE1, REG_CS, BUSY} !== 13'b1111100000000) begin
            n_err++; $display("FAIL reset_values got %b want 1111100000000",
                              {REQn, FRAMEn, IRDYn, TAn, TEAn, AD_OE, CBE, CFG_TYPE1, REG_CS, BUSY});
        end
        @(negedge CLK40);
        RESET = 1'b0;
    endtask

    task automatic test_cfg0_read();
        run_cycle("cfg0_read", mk(1, 1, 0, 0, 0, 1, 0, RSP_DATA, 2, 1));
    endtask

    task automatic test_reg_write();
        run_cycle("reg_write", mk(0, 0, 0, 0, 1, 0, 0, RSP_DATA, 1, 0));
    endtask

    task automatic test_mem_retry();
        run_cycle("mem_wr_retry3", mk(0, 0, 0, 0, 0, 0, 3, RSP_DATA, 1, 0));
        run_cycle("mem_wr_retry_limit", mk(0, 0, 0, 0, 0, 0, 0, RSP_RETRY, 1, 0));
    endtask

    task automatic test_master_abort();
        run_cycle("io_rd_mabort", mk(1, 0, 0, 1, 0, 0, 0, RSP_NONE, 1, 0));
        run_cycle("cfg1_rd_mabort", mk(1, 0, 1, 0, 0, 2, 0, RSP_NONE, 1, 0));
        run_cycle("cfg_io_prio_wr", mk(0, 1, 0, 1, 0, 0, 0, RSP_DATA, 1, 0));
    endtask

    task automatic test_target_abort();
        run_cycle("mem_rd_tabort", mk(1, 0, 0, 0, 0, 0, 0, RSP_TABT, 2, 0));
        run_cycle("gnt_timeout", mk(0, 0, 0, 0, 0, NEVER, 0, RSP_DATA, 1, 0));
    endtask

    task automatic test_disconnect_and_busy_ts();
        scen_t s;
        s = mk(1, 0, 0, 1, 0, 0, 1, RSP_DATA, 1, 0);
        s.dwd = 1'b1; s.busy_ts = 1'b1;
        run_cycle("io_rd_disc_data", s);
    endtask

    task automatic test_bridge_en_ignored();
        int n_busy = 0;
        @(negedge CLK40);
        TSn = 1'b0; BRIDGE_ENn = 1'b1; BRIDGE_REG_SPACE = 1'b1;
        @(negedge CLK40);
        TSn = 1'b1;
        repeat (3) begin if (BUSY !== 1'b0) n_busy++; @(negedge CLK40); end
        n_vec++;
        if (n_busy != 0) begin n_err++; $display("FAIL bridge_en_ignored busy_clocks got %0d want 0", n_busy); end
    endtask

    task automatic test_reset_mid();
        int guard = 0, n_ack = 0, n_busy = 0;
        @(negedge CLK40);
        GNTn = 1'b0; TSn = 1'b0; RWn = 1'b0; BRIDGE_ENn = 1'b0;
        CONFIG0_SPACE = 1'b0; CONFIG1_SPACE = 1'b0; IO_SPACE = 1'b0; BRIDGE_REG_SPACE = 1'b0;
        @(negedge CLK40);
        TSn = 1'b1;
        while (IRDYn && guard < 20) begin @(negedge CLK40); guard++; end
        n_vec++;
        if (IRDYn !== 1'b0) begin n_err++; $display("FAIL reset_mid reach_data irdy got %b want 0", IRDYn); end
        #3 RESET = 1'b1;
        #1;
        n_vec++;
        if ({REQn, FRAMEn, IRDYn, AD_OE, BUSY} !== 5'b11100) begin
            n_err++; $display("FAIL reset_mid async_release got %b want 11100", {REQn, FRAMEn, IRDYn, AD_OE, BUSY});
        end
        GNTn = 1'b1;
        @(negedge CLK40);
        RESET = 1'b0;
        repeat (8) begin
            if (!TAn || !TEAn) n_ack++;
            if (BUSY) n_busy++;
            @(negedge CLK40);
        end
        n_vec++;
        if (n_ack != 0) begin n_err++; $display("FAIL reset_mid ack_after_reset got %0d want 0", n_ack); end
        n_vec++;
        if (n_busy != 0) begin n_err++; $display("FAIL reset_mid busy_after_reset got %0d want 0", n_busy); end
        run_cycle("post_reset_mem_wr", mk(0, 0, 0, 0, 0, 1, 0, RSP_DATA, 1, 1));
    endtask

    task automatic test_random();
        scen_t s;
        bit [2:0] sp;
        for (int i = 0; i < 24; i++) begin
            sp = 3'($urandom_range(0, 4));
            s = mk(1'($urandom), sp == 1, sp == 2, sp == 3, sp == 4,
                   ($urandom_range(0, 15) == 0) ? NEVER : int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 3)), int'($urandom_range(0, 1)));
            if (s.fin == RSP_RETRY) s.fin = RSP_DATA;
            s.dwd = 1'($urandom);
            s.busy_ts = 1'($urandom);
            run_cycle($sformatf("random_%0d", i), s);
        end
    endtask

    task automatic test_back_to_back();
        run_cycle("b2b_reg", mk(1, 0, 0, 0, 1, 0, 0, RSP_DATA, 1, 0));
        run_cycle("b2b_mem_rd", mk(1, 0, 0, 0, 0, 0, 0, RSP_DATA, 1, 0));
        run_cycle("b2b_cfg0_wr_mabort", mk(0, 1, 0, 0, 0, 0, 0, RSP_NONE, 1, 0));
    endtask

    initial begin
        test_reset();
        test_cfg0_read();
        test_reg_write();
        test_mem_retry();
        test_master_abort();
        test_target_abort();
        test_disconnect_and_busy_ts();
        test_bridge_en_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
